ppm_symbol_demod: RTL and testbench

Front-end demodulator of the PPM decoder. It samples the raw 4-PPM line on the 16x clock and finds frame start from a start pulse. For each 4-chip symbol it emits one 2-bit value, encoded as a 3-bit symbol word plus a one-cycle strobe. These outputs drive the byte assembler's `data_3bits_in`/`finish2bits` inputs directly.

---
 rtl/ppm_pkg.sv | 23 ++
 rtl/ppm_symbol_demod_if.sv | 27 ++
 rtl/ppm_sync_edge.sv | 35 +++
 rtl/ppm_symbol_demod.sv | 151 +++++++++++++++
 tb/tb_ppm_symbol_demod.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ppm_pkg.sv
// Shared definitions for the PPM decoder: demodulator state encoding, the
// idle symbol word also consumed by the byte assembler, the default chip
// length and a helper that locates the pulse in a one-hot chip vector.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [2:0] SYM_IDLE        = 3'b100;
  localparam int         CHIP_CYCLES_DEF = 4;

  // Position of the highest set chip; only meaningful for one-hot input.
  function automatic logic [1:0] chip_pos(input logic [3:0] chips);
    chip_pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (chips[i]) chip_pos = 2'(i);
    end
  endfunction

endpackage

// File: rtl/ppm_symbol_demod_if.sv
// Line/symbol bundle between the PPM line, the demodulator and the byte
// assembler.
//   ppm_in         : raw asynchronous PPM line (idle low)
//   data_3bits_out : symbol word, 3'b0xx during strobe, 3'b100 otherwise
//   finish2bits    : one-cycle strobe qualifying data_3bits_out
//   frame_active   : high while a frame is being decoded
//   sym_err        : one-cycle pulse for a malformed symbol
//   frame_end      : one-cycle pulse when a frame terminates
// master = demodulator side, slave = line driver / symbol consumer side.
interface ppm_symbol_demod_if;
  logic       ppm_in;
  logic [2:0] data_3bits_out;
  logic       finish2bits;
  logic       frame_active;
  logic       sym_err;
  logic       frame_end;

  modport master (
    input  ppm_in,
    output data_3bits_out, finish2bits, frame_active, sym_err, frame_end
  );

  modport slave (
    output ppm_in,
    input  data_3bits_out, finish2bits, frame_active, sym_err, frame_end
  );
endinterface

// File: rtl/ppm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PPM line plus one delay flop
// for rising-edge detection.
//   clk      : sampling clock
//   rst      : synchronous active-high reset
//   i_ppm    : raw asynchronous line
//   o_ppm_s  : synchronized line
//   o_rise   : one-cycle pulse on a 0->1 transition of o_ppm_s
module ppm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_ppm,
  output logic o_ppm_s,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_ppm;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_ppm_s = r_sync;
  assign o_rise  = r_sync & ~r_dly;

endmodule

// File: rtl/ppm_symbol_demod.sv
// 4-PPM symbol demodulator. Locks onto a start pulse, then mid-samples each
// chip of every 4-chip symbol and emits one 2-bit value per symbol as a
// 3-bit word plus strobe. Two consecutive empty symbols end the frame.
//   clk16 : 16x oversampling clock
//   rst   : synchronous active-high reset
//   bus   : line input and registered symbol/status outputs (master side)
module ppm_symbol_demod
  import ppm_pkg::*;
#(
  parameter int CHIP_CYCLES = CHIP_CYCLES_DEF
) (
  input  logic                clk16,
  input  logic                rst,
  ppm_symbol_demod_if.master  bus
);

  localparam int            CW   = (CHIP_CYCLES > 2) ? $clog2(CHIP_CYCLES) : 1;
  localparam logic [CW-1:0] MID  = CW'(CHIP_CYCLES / 2);
  localparam logic [CW-1:0] LAST = CW'(CHIP_CYCLES - 1);

  logic w_ppm_s;
  logic w_rise;

  ppm_sync_edge u_sync (
    .clk     (clk16),
    .rst     (rst),
    .i_ppm   (bus.ppm_in),
    .o_ppm_s (w_ppm_s),
    .o_rise  (w_rise)
  );

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]    r_idx,   w_idx_nxt;
  logic [3:0]    r_chips, w_chips_nxt;
  logic          r_empty, w_empty_nxt;   // one empty symbol already seen
  logic [2:0]    r_data,  w_data_nxt;
  logic          r_fin,   w_fin_nxt;
  logic          r_err,   w_err_nxt;
  logic          r_end,   w_end_nxt;
  logic          r_act,   w_act_nxt;

  logic w_mid;
  logic w_last;

  assign w_mid  = (r_cnt == MID);
  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_chips_nxt = r_chips;
    w_empty_nxt = r_empty;
    w_data_nxt  = SYM_IDLE;
    w_fin_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_end_nxt   = 1'b0;
    w_act_nxt   = r_act;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) w_state_nxt = START;
      end

      START: begin
        // A start pulse that is gone by mid-chip is treated as a glitch.
        if (w_mid && !w_ppm_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 2'd0;
          w_chips_nxt = '0;
          w_empty_nxt = 1'b0;
          w_act_nxt   = 1'b1;
        end
      end

      DATA: begin
        if (w_mid) w_chips_nxt[r_idx] = w_ppm_s;
        if (w_last) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + 2'd1;
          // Chip 3 was mid-sampled earlier in this chip, so r_chips is complete.
          if (r_idx == 2'd3) begin
            case ($countones(r_chips))
              1: begin
                w_data_nxt  = {1'b0, chip_pos(r_chips)};
                w_fin_nxt   = 1'b1;
                w_empty_nxt = 1'b0;
              end
              0: begin
                if (r_empty) begin
                  w_end_nxt   = 1'b1;
                  w_act_nxt   = 1'b0;
                  w_empty_nxt = 1'b0;
                  w_state_nxt = IDLE;
                end else begin
                  w_err_nxt   = 1'b1;
                  w_empty_nxt = 1'b1;
                end
              end
              default: begin
                w_err_nxt   = 1'b1;
                w_empty_nxt = 1'b0;
              end
            endcase
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk16) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_chips <= '0;
      r_empty <= 1'b0;
      r_data  <= SYM_IDLE;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
      r_end   <= 1'b0;
      r_act   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_chips <= w_chips_nxt;
      r_empty <= w_empty_nxt;
      r_data  <= w_data_nxt;
      r_fin   <= w_fin_nxt;
      r_err   <= w_err_nxt;
      r_end   <= w_end_nxt;
      r_act   <= w_act_nxt;
    end
  end

  assign bus.data_3bits_out = r_data;
  assign bus.finish2bits    = r_fin;
  assign bus.sym_err        = r_err;
  assign bus.frame_end      = r_end;
  assign bus.frame_active   = r_act;

endmodule

// File: tb/tb_ppm_symbol_demod.sv
// Self-checking bench for ppm_symbol_demod. The whole run is planned up
// front as per-cycle tables: the PPM waveform to drive and the outputs
// expected, derived from frame-level rules (start chip, 16-cycle symbols,
// fixed decode latency, empty-symbol termination).
module tb_ppm_symbol_demod;

  localparam int MAXC = 4096;
  localparam int CC   = 4;

  logic clk16 = 1'b0;
  logic rst   = 1'b1;

  ppm_symbol_demod_if bus();

  ppm_symbol_demod #(.CHIP_CYCLES(CC)) dut (
    .clk16 (clk16),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk16 = ~clk16;

  // drv[n]/rstv[n] are applied just after edge n and sampled at edge n+1;
  // e_*[n] are the outputs expected after edge n.
  bit         drv   [MAXC];
  bit         rstv  [MAXC];
  logic [2:0] e_data[MAXC];
  bit         e_fin [MAXC];
  bit         e_err [MAXC];
  bit         e_end [MAXC];
  bit         e_act [MAXC];

  logic [3:0] pq[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit run   = 0;

  // Start pulse occupies chip slot s..s+3; symbol k chip c occupies the
  // slot s+4+16k+4c. The decision for symbol k appears after edge s+23+16k.
  task automatic plan_frame(input int s, output int nxt);
    int  endt;
    bit  ended;
    bit  empty;
    int  t;
    int  ones;
    int  pos;
    for (int j = 0; j < CC; j++) drv[s + j] = 1;
    ended = 0;
    empty = 0;
    endt  = s + 23;
    for (int k = 0; k < pq.size(); k++) begin
      for (int c = 0; c < 4; c++)
        if (pq[k][c])
          for (int j = 0; j < CC; j++) drv[s + 4 + 16 * k + 4 * c + j] = 1;
      t    = s + 23 + 16 * k;
      endt = t;
      ones = 0;
      pos  = 0;
      for (int c = 0; c < 4; c++) if (pq[k][c]) begin ones++; pos = c; end
      if (ones == 1) begin
        e_fin[t]  = 1;
        e_data[t] = 3'(pos);
        empty     = 0;
      end else if (ones == 0) begin
        if (empty) begin
          e_end[t] = 1;
          ended    = 1;
          break;
        end
        e_err[t] = 1;
        empty    = 1;
      end else begin
        e_err[t] = 1;
        empty    = 0;
      end
    end
    for (int c = s + 7; c < (ended ? endt : endt + 1); c++) e_act[c] = 1;
    nxt = endt + 10;
  endtask

  task automatic apply_reset(input int r);
    rstv[r] = 1;
    for (int c = r; c < MAXC; c++) drv[c] = 0;
    for (int c = r + 1; c < MAXC; c++) begin
      e_data[c] = 3'b100; e_fin[c] = 0; e_err[c] = 0; e_end[c] = 0; e_act[c] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk16) begin
    if (run && cyc >= 1) begin
      chk("data",   bus.data_3bits_out, e_data[cyc]);
      chk("fin",    {2'b0, bus.finish2bits},  {2'b0, e_fin[cyc]});
      chk("err",    {2'b0, bus.sym_err},      {2'b0, e_err[cyc]});
      chk("fend",   {2'b0, bus.frame_end},    {2'b0, e_end[cyc]});
      chk("active", {2'b0, bus.frame_active}, {2'b0, e_act[cyc]});
      // Hand-derived anchors for the basic frame starting at slot 10.
      case (cyc)
        3:   chk("pin_reset_data", bus.data_3bits_out, 3'b100);
        33:  chk("pin_sym0_chip1", bus.data_3bits_out, 3'b001);
        49:  chk("pin_sym1_chip0", bus.data_3bits_out, 3'b000);
        65:  chk("pin_sym2_chip2", bus.data_3bits_out, 3'b010);
        81:  chk("pin_sym3_chip3", bus.data_3bits_out, 3'b011);
        97:  chk("pin_first_empty_err", {2'b0, bus.sym_err}, 3'b001);
        113: chk("pin_frame_end", {2'b0, bus.frame_end}, 3'b001);
        114: chk("pin_active_low", {2'b0, bus.frame_active}, 3'b000);
        default: ;
      endcase
    end
  end

  initial begin
    int s;
    int nxt;
    int r;
    int len;
    int v;
    for (int i = 0; i < MAXC; i++) begin
      drv[i] = 0; rstv[i] = 0; e_data[i] = 3'b100;
      e_fin[i] = 0; e_err[i] = 0; e_end[i] = 0; e_act[i] = 0;
    end
    rstv[0] = 1; rstv[1] = 1; rstv[2] = 1;

    // Basic frame: chips 1,0,2,3 then two empty symbols.
    pq = '{4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    plan_frame(10, nxt);

    // One-cycle start glitch: no frame.
    s = nxt;
    drv[s] = 1;
    s = s + 12;

    // Double pulse, chip-spanning pulse, lone empty symbol.
    pq = '{4'b0101, 4'b1000, 4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    plan_frame(s, nxt);

    // Reset in the middle of the second symbol, then a normal frame.
    s  = nxt;
    pq = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    plan_frame(s, nxt);
    r = s + 4 + 16 + 6;
    apply_reset(r);
    s  = r + 10;
    pq = '{4'b1000, 4'b0001, 4'b0000, 4'b0000};
    plan_frame(s, nxt);

    // Long frame: 64 random valid symbols.
    s = nxt;
    pq.delete();
    for (int k = 0; k < 64; k++) pq.push_back(4'b0001 << $urandom_range(0, 3));
    pq.push_back(4'b0000); pq.push_back(4'b0000);
    plan_frame(s, nxt);

    // Random frames mixing valid, empty and multi-pulse symbols.
    for (int f = 0; f < 4; f++) begin
      s = nxt;
      pq.delete();
      len = $urandom_range(3, 10);
      for (int k = 0; k < len; k++) begin
        v = $urandom_range(0, 9);
        if (v < 7)       pq.push_back(4'b0001 << $urandom_range(0, 3));
        else if (v == 7) pq.push_back(4'b0000);
        else             pq.push_back(4'($urandom_range(0, 15)));
      end
      pq.push_back(4'b0000); pq.push_back(4'b0000);
      plan_frame(s, nxt);
    end

    rst        = rstv[0];
    bus.ppm_in = drv[0];
    cyc        = 0;
    run        = 1;
    for (int n = 1; n <= nxt; n++) begin
      @(posedge clk16);
      cyc = n;
      #1;
      rst        = rstv[n];
      bus.ppm_in = drv[n];
    end
    @(posedge clk16);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
